// File: rtl/memory_access_unit_if.sv
// Signal bundle between the memory-access stage, its upstream/downstream stages and data memory.
// master is the memory-access unit itself; slave is everything around it.
interface memory_access_unit_if;
  logic        valid_in;
  logic [31:0] instr_in;
  logic        branch_in;
  logic        branch_ref;
  logic        sel_stall;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        valid_out;
  logic [31:0] instr_output;
  logic        branch_value;
  logic [31:0] load_data;
  logic        timeout_err;

  modport master (
    input  valid_in, instr_in, branch_in, branch_ref, sel_stall,
           alu_result, store_data, mem_ack, mem_rdata,
    output stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           valid_out, instr_output, branch_value, load_data, timeout_err
  );

  modport slave (
    output valid_in, instr_in, branch_in, branch_ref, sel_stall,
           alu_result, store_data, mem_ack, mem_rdata,
    input  stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           valid_out, instr_output, branch_value, load_data, timeout_err
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: owns the LDR/STR data-memory req/ack transaction and
// forwards instruction, branch tag and load data to the memory-wait stage.
module memory_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'hE1A00000
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_access_unit_if.master bus
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state, state_nxt;

  function automatic logic [31:0] lane_replicate(input logic [31:0] d, input logic is_byte);
    return is_byte ? {4{d[7:0]}} : d;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] lo, input logic is_byte);
    return is_byte ? (4'b0001 << lo) : 4'hF;
  endfunction

  function automatic logic [31:0] access_addr(input logic [31:0] a, input logic is_byte);
    return is_byte ? a : {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] d, input logic [1:0] lo,
                                              input logic is_byte);
    logic [7:0] b;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return is_byte ? {24'b0, b} : d;
  endfunction

  logic             req_p0, we_p0, done_p0, byte_p0, branch_p0;
  logic [31:0]      addr_p0, wdata_p0, instr_p0, rdata_p0;
  logic [3:0]       be_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             vld_p1, branch_p1, err_sticky;
  logic [31:0]      instr_p1, ld_p1;

  logic is_mem, squash, accept, ack_hit, timeout_hit, present;

  assign is_mem      = bus.instr_in[27:26] == 2'b01;
  assign squash      = bus.branch_in != bus.branch_ref;
  assign accept      = (state == IDLE) && bus.valid_in && !bus.sel_stall;
  assign ack_hit     = (state == BUSY) && !done_p0 && bus.mem_ack;
  assign timeout_hit = (state == BUSY) && !done_p0 && !bus.mem_ack && (cnt_p0 == CNT_LAST);
  // An ack taken during a downstream stall is parked in done_p0/rdata_p0 until the stall lifts.
  assign present     = (state == BUSY) && (ack_hit || done_p0) && !bus.sel_stall;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem && !squash) state_nxt = BUSY;
      BUSY: begin
        if (present)          state_nxt = IDLE;
        else if (timeout_hit) state_nxt = ERR;
      end
      ERR:     if (!bus.sel_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: memory request latched at accept; stage p1: result presented downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_p0     <= 1'b0;
      we_p0      <= 1'b0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      be_p0      <= '0;
      cnt_p0     <= '0;
      done_p0    <= 1'b0;
      vld_p1     <= 1'b0;
      instr_p1   <= NOP_INSTR;
      branch_p1  <= 1'b0;
      ld_p1      <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vld_p1 <= squash || !is_mem;
            if (squash) begin
              instr_p1  <= NOP_INSTR;
              branch_p1 <= bus.branch_in;
            end else if (!is_mem) begin
              instr_p1  <= bus.instr_in;
              branch_p1 <= bus.branch_in;
            end else begin
              req_p0   <= 1'b1;
              we_p0    <= !bus.instr_in[20];
              addr_p0  <= access_addr(bus.alu_result, bus.instr_in[22]);
              wdata_p0 <= lane_replicate(bus.store_data, bus.instr_in[22]);
              be_p0    <= byte_enable(bus.alu_result[1:0], bus.instr_in[22]);
              cnt_p0   <= '0;
              done_p0  <= 1'b0;
            end
          end else if (!bus.sel_stall) begin
            vld_p1 <= 1'b0;
          end
        end
        BUSY: begin
          if (ack_hit || timeout_hit) req_p0 <= 1'b0;
          if (timeout_hit)                       err_sticky <= 1'b1;
          else if (!done_p0 && !bus.mem_ack)     cnt_p0 <= cnt_p0 + 1'b1;
          if (ack_hit && bus.sel_stall)          done_p0 <= 1'b1;
          if (present) begin
            vld_p1    <= 1'b1;
            instr_p1  <= instr_p0;
            branch_p1 <= branch_p0;
            ld_p1     <= we_p0 ? '0 :
                         load_format(done_p0 ? rdata_p0 : bus.mem_rdata, addr_p0[1:0], byte_p0);
            done_p0   <= 1'b0;
          end else if (!bus.sel_stall) begin
            vld_p1 <= 1'b0;
          end
        end
        ERR: begin
          if (!bus.sel_stall) begin
            vld_p1    <= 1'b1;
            instr_p1  <= NOP_INSTR;
            branch_p1 <= branch_p0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      instr_p0  <= bus.instr_in;
      branch_p0 <= bus.branch_in;
      byte_p0   <= bus.instr_in[22];
    end
    if (ack_hit) rdata_p0 <= bus.mem_rdata;
  end

  assign bus.stall_out    = (state != IDLE) || bus.sel_stall;
  assign bus.mem_req      = req_p0;
  assign bus.mem_we       = we_p0;
  assign bus.mem_addr     = addr_p0;
  assign bus.mem_wdata    = wdata_p0;
  assign bus.mem_be       = be_p0;
  assign bus.valid_out    = vld_p1;
  assign bus.instr_output = instr_p1;
  assign bus.branch_value = branch_p1;
  assign bus.load_data    = ld_p1;
  assign bus.timeout_err  = err_sticky;
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: stimulus pushes expected results into a scoreboard,
// a negedge monitor pops them whenever the stage presents a result downstream.
module tb_memory_access_unit;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_access_unit_if bus ();

  memory_access_unit #(.TIMEOUT_CYCLES(4), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic        br;
    logic [31:0] ld;
    logic        chk_ld;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] addr,
                       input logic [31:0] sd, input logic br);
    bus.valid_in   = 1'b1;
    bus.instr_in   = instr;
    bus.alu_result = addr;
    bus.store_data = sd;
    bus.branch_in  = br;
    tick();
    bus.valid_in   = 1'b0;
  endtask

  task automatic expect_out(input logic [31:0] instr, input logic br,
                            input logic [31:0] ld, input logic chk_ld);
    exp_t e;
    e.instr = instr; e.br = br; e.ld = ld; e.chk_ld = chk_ld;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.valid_out && !bus.sel_stall) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 32'(bus.valid_out), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", bus.instr_output, e.instr);
        chk("sb_branch", 32'(bus.branch_value), 32'(e.br));
        if (e.chk_ld) chk("sb_load_data", bus.load_data, e.ld);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_n;
    int req_n;
    bus.valid_in   = 1'b0;
    bus.instr_in   = '0;
    bus.branch_in  = 1'b0;
    bus.branch_ref = 1'b0;
    bus.sel_stall  = 1'b0;
    bus.alu_result = '0;
    bus.store_data = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    tick();
    tick();
    chk("rst_valid_out", 32'(bus.valid_out), 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'h0);
    chk("rst_instr_output", bus.instr_output, NOP);
    chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_load_data", bus.load_data, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_stall_out", 32'(bus.stall_out), 32'h0);

    // Non-memory instruction: one-cycle latency, no memory request
    expect_out(32'hE0812003, 1'b0, 32'h0, 1'b0);
    issue(32'hE0812003, 32'h0, 32'h0, 1'b0);
    chk("nm_valid_out", 32'(bus.valid_out), 32'h1);
    chk("nm_mem_req", 32'(bus.mem_req), 32'h0);
    tick();
    chk("nm_mem_req_after", 32'(bus.mem_req), 32'h0);

    // LDR word, ack three cycles after the request rises
    expect_out(32'hE5910000, 1'b0, 32'hDEADBEEF, 1'b1);
    issue(32'hE5910000, 32'h00001006, 32'h0, 1'b0);
    chk("ldr_mem_req", 32'(bus.mem_req), 32'h1);
    chk("ldr_mem_addr", bus.mem_addr, 32'h00001004);
    chk("ldr_mem_be", 32'(bus.mem_be), 32'hF);
    chk("ldr_mem_we", 32'(bus.mem_we), 32'h0);
    stall_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.stall_out) stall_n++;
      if (i == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    if (bus.stall_out) stall_n++;
    chk("ldr_stall_cycles", 32'(stall_n), 32'd4);
    chk("ldr_valid_out", 32'(bus.valid_out), 32'h1);
    chk("ldr_load_data", bus.load_data, 32'hDEADBEEF);
    tick();
    chk("ldr_mem_req_drop", 32'(bus.mem_req), 32'h0);

    // STRB with immediate ack: minimum two-cycle latency
    expect_out(32'hE5C10000, 1'b0, 32'h0, 1'b0);
    issue(32'hE5C10000, 32'h00002003, 32'h000000A5, 1'b0);
    chk("strb_mem_be", 32'(bus.mem_be), 32'h8);
    chk("strb_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    chk("strb_mem_we", 32'(bus.mem_we), 32'h1);
    chk("strb_mem_addr", bus.mem_addr, 32'h00002003);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.mem_ack = 1'b0;
    chk("strb_latency_valid", 32'(bus.valid_out), 32'h1);
    chk("strb_mem_req_drop", 32'(bus.mem_req), 32'h0);
    tick();

    // Squashed LDR: tag mismatch
    expect_out(NOP, 1'b1, 32'h0, 1'b0);
    issue(32'hE5910000, 32'h00001000, 32'h0, 1'b1);
    bus.branch_in = 1'b0;
    chk("sq_mem_req", 32'(bus.mem_req), 32'h0);
    chk("sq_valid_out", 32'(bus.valid_out), 32'h1);
    chk("sq_instr", bus.instr_output, NOP);
    tick();
    chk("sq_mem_req_after", 32'(bus.mem_req), 32'h0);

    // LDRB with ack arriving during a downstream stall
    expect_out(32'hE5D10000, 1'b0, 32'h00000022, 1'b1);
    issue(32'hE5D10000, 32'h00003002, 32'h0, 1'b0);
    chk("ldrb_mem_addr", bus.mem_addr, 32'h00003002);
    chk("ldrb_mem_be", 32'(bus.mem_be), 32'h4);
    bus.sel_stall = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11223344;
    tick();
    bus.mem_ack = 1'b0;
    chk("ldrb_req_drop", 32'(bus.mem_req), 32'h0);
    chk("ldrb_deferred", 32'(bus.valid_out), 32'h0);
    chk("ldrb_stall_out", 32'(bus.stall_out), 32'h1);
    tick();
    chk("ldrb_still_deferred", 32'(bus.valid_out), 32'h0);
    bus.sel_stall = 1'b0;
    tick();
    chk("ldrb_valid_out", 32'(bus.valid_out), 32'h1);
    chk("ldrb_load_data", bus.load_data, 32'h00000022);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_mem_req", 32'(bus.mem_req), 32'h0);
    chk("late_ack_valid_out", 32'(bus.valid_out), 32'h0);

    // Timeout: no ack, TIMEOUT_CYCLES = 4
    expect_out(NOP, 1'b0, 32'h0, 1'b0);
    issue(32'hE5910000, 32'h00000040, 32'h0, 1'b0);
    req_n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req) req_n++;
      if (i == 2) chk("to_err_early", 32'(bus.timeout_err), 32'h0);
      if (i == 4) begin
        chk("to_err_set", 32'(bus.timeout_err), 32'h1);
        bus.mem_ack = 1'b1;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("to_req_cycles", 32'(req_n), 32'd4);
    chk("to_nop_valid", 32'(bus.valid_out), 32'h1);
    chk("to_nop_instr", bus.instr_output, NOP);
    tick();
    tick();
    tick();
    chk("to_err_sticky", 32'(bus.timeout_err), 32'h1);

    // Reset while BUSY abandons the transaction
    issue(32'hE5910000, 32'h00000050, 32'h0, 1'b0);
    chk("rb_mem_req", 32'(bus.mem_req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_mem_req_drop", 32'(bus.mem_req), 32'h0);
    chk("rb_timeout_err", 32'(bus.timeout_err), 32'h0);
    chk("rb_mem_addr", bus.mem_addr, 32'h0);
    chk("rb_instr", bus.instr_output, NOP);
    chk("rb_stall_out", 32'(bus.stall_out), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_ack = 1'b0;
    chk("rb_late_ack_valid", 32'(bus.valid_out), 32'h0);
    chk("rb_late_ack_req", 32'(bus.mem_req), 32'h0);

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
